cnn_layer_accel_seq_fetch: RTL and testbench

//  Sequencer-word prefetcher upstream of the quad. Reads seq_len words from sequence memory starting at seq_base,

---
 rtl/cnn_layer_accel_seq_fetch_if.sv | 23 ++
 rtl/cnn_layer_accel_seq_fetch.sv | 205 ++++++++++++++++++++
 tb/tb_cnn_layer_accel_seq_fetch.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_layer_accel_seq_fetch_if.sv
// Sequence-fetch bus: memory read port towards sequence memory and pop port towards the quad.
// The master modport is the prefetcher side.
interface cnn_layer_accel_seq_fetch_if #(
  parameter int unsigned W = 16,
  parameter int unsigned A = 12
);
  logic         mem_rd_en;
  logic [A-1:0] mem_rd_addr;
  logic [W-1:0] mem_rd_data;
  logic         seq_rden;
  logic [W-1:0] seq_dataout;
  logic         seq_dataout_valid;

  modport master (
    output mem_rd_en, mem_rd_addr, seq_dataout, seq_dataout_valid,
    input  mem_rd_data, seq_rden
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, seq_dataout, seq_dataout_valid,
    output mem_rd_data, seq_rden
  );
endinterface

// File: rtl/cnn_layer_accel_seq_fetch.sv
// Sequencer-word prefetcher: streams seq_len words x num_passes from sequence memory into a
// small first-word-fall-through FIFO so the quad sees one word per seq_rden.
module cnn_layer_accel_seq_fetch #(
  parameter int unsigned C_SEQ_DATA_WIDTH = 16,
  parameter int unsigned C_SEQ_DATA_DEPTH = 2560,
  parameter int unsigned C_MEM_LATENCY    = 2,
  parameter int unsigned C_FIFO_DEPTH     = 8
) (
  input  logic                                  clk_500MHz,
  input  logic                                  accel_rst_n,
  input  logic                                  i_start,
  input  logic [$clog2(C_SEQ_DATA_DEPTH)-1:0]   i_seq_base,
  input  logic [$clog2(C_SEQ_DATA_DEPTH):0]     i_seq_len,
  input  logic [15:0]                           i_num_passes,
  output logic                                  o_busy,
  output logic                                  o_done,
  output logic                                  o_underrun,
  cnn_layer_accel_seq_fetch_if.master           seq_if
);

  localparam int unsigned W   = C_SEQ_DATA_WIDTH;
  localparam int unsigned A   = $clog2(C_SEQ_DATA_DEPTH);
  localparam int unsigned AW1 = A + 1;
  localparam int unsigned L   = C_MEM_LATENCY;
  localparam int unsigned PW  = $clog2(C_FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned IW  = $clog2(C_MEM_LATENCY + 2);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_PREFILL = 4'b0010,
    ST_STREAM  = 4'b0100,
    ST_DRAIN   = 4'b1000
  } state_t;

  state_t          r_state;
  logic [A-1:0]    r_base;
  logic [AW1-1:0]  r_len;
  logic [15:0]     r_passes;
  logic [AW1-1:0]  r_offset;
  logic [15:0]     r_pass;
  logic            r_all_issued;
  logic            r_mem_rd_en;
  logic [A-1:0]    r_mem_rd_addr;
  logic [L-1:0]    r_sr;
  logic [W-1:0]    r_fifo [C_FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [W-1:0]    r_dout;
  logic            r_dout_valid;
  logic            r_busy;
  logic            r_done;
  logic            r_underrun;

  logic [IW-1:0]   w_inflight;
  logic            w_issue;
  logic            w_last;
  logic            w_off_wrap;
  logic [AW1-1:0]  w_sum;
  logic [A-1:0]    w_addr;
  logic            w_wr;
  logic            w_pop;
  logic [CW-1:0]   w_count_nxt;
  logic [PW-1:0]   w_rd_ptr_nxt;
  logic [L-1:0]    w_sr_nxt;
  logic [W-1:0]    w_head_nxt;

  // Outstanding reads: the strobe on the bus now plus every stage of the return pipe.
  always_comb begin
    w_inflight = IW'(r_mem_rd_en);
    for (int i = 0; i < int'(L); i++) begin
      w_inflight = w_inflight + IW'(r_sr[i]);
    end
    w_sr_nxt    = '0;
    w_sr_nxt[0] = r_mem_rd_en;
    for (int i = 1; i < int'(L); i++) begin
      w_sr_nxt[i] = r_sr[i-1];
    end
  end

  always_comb begin
    w_off_wrap   = (r_offset == (r_len - AW1'(1)));
    w_last       = w_off_wrap && (r_pass == (r_passes - 16'd1));
    w_issue      = ((r_state == ST_PREFILL) || (r_state == ST_STREAM)) && !r_all_issued &&
                   ((32'(r_count) + 32'(w_inflight)) < 32'(C_FIFO_DEPTH));
    w_sum        = AW1'(r_base) + r_offset;
    w_addr       = (w_sum >= AW1'(C_SEQ_DATA_DEPTH)) ? A'(w_sum - AW1'(C_SEQ_DATA_DEPTH)) : A'(w_sum);
    w_wr         = r_sr[L-1];
    w_pop        = seq_if.seq_rden && r_dout_valid;
    w_count_nxt  = r_count + CW'(w_wr) - CW'(w_pop);
    w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);
    // Bypass when the next head is the slot being written this cycle.
    w_head_nxt   = (w_wr && (w_rd_ptr_nxt == r_wr_ptr)) ? seq_if.mem_rd_data : r_fifo[w_rd_ptr_nxt];
  end

  always_ff @(posedge clk_500MHz or negedge accel_rst_n) begin
    if (!accel_rst_n) begin
      r_state       <= ST_IDLE;
      r_base        <= '0;
      r_len         <= '0;
      r_passes      <= '0;
      r_offset      <= '0;
      r_pass        <= '0;
      r_all_issued  <= 1'b0;
      r_mem_rd_en   <= 1'b0;
      r_mem_rd_addr <= '0;
      r_sr          <= '0;
      r_dout_valid  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_mem_rd_en <= w_issue;
      r_sr        <= w_sr_nxt;
      if (w_issue) begin
        r_mem_rd_addr <= w_addr;
        if (w_off_wrap) begin
          r_offset <= '0;
          r_pass   <= r_pass + 16'd1;
        end else begin
          r_offset <= r_offset + AW1'(1);
        end
        if (w_last) r_all_issued <= 1'b1;
      end
      if (seq_if.seq_rden && !r_dout_valid) r_underrun <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          r_dout_valid <= 1'b0;
          if (i_start) begin
            r_base       <= i_seq_base;
            r_len        <= i_seq_len;
            r_passes     <= i_num_passes;
            r_offset     <= '0;
            r_pass       <= '0;
            r_all_issued <= 1'b0;
            r_underrun   <= 1'b0;
            if ((i_seq_len == '0) || (i_num_passes == '0)) begin
              r_done <= 1'b1;
            end else begin
              r_state <= ST_PREFILL;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_PREFILL: begin
          r_dout_valid <= 1'b0;
          if ((r_count == CW'(C_FIFO_DEPTH)) || (r_all_issued && (w_inflight == '0))) begin
            r_state      <= ST_STREAM;
            r_dout_valid <= (w_count_nxt != '0);
          end
        end
        ST_STREAM: begin
          r_dout_valid <= (w_count_nxt != '0);
          if ((w_issue && w_last) || r_all_issued) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if ((w_count_nxt == '0) && (w_sr_nxt == '0)) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_dout_valid <= 1'b0;
          end else begin
            r_dout_valid <= (w_count_nxt != '0);
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
          r_dout_valid <= 1'b0;
        end
      endcase
    end
  end

  // Prefetch FIFO storage, pointers and registered head.
  always_ff @(posedge clk_500MHz or negedge accel_rst_n) begin
    if (!accel_rst_n) begin
      for (int i = 0; i < int'(C_FIFO_DEPTH); i++) r_fifo[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
    end else begin
      if (w_wr) begin
        r_fifo[r_wr_ptr] <= seq_if.mem_rd_data;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_dout   <= w_head_nxt;
    end
  end

  assign seq_if.mem_rd_en         = r_mem_rd_en;
  assign seq_if.mem_rd_addr       = r_mem_rd_addr;
  assign seq_if.seq_dataout       = r_dout;
  assign seq_if.seq_dataout_valid = r_dout_valid;
  assign o_busy                   = r_busy;
  assign o_done                   = r_done;
  assign o_underrun               = r_underrun;

endmodule

// File: tb/tb_cnn_layer_accel_seq_fetch.sv
// Self-checking bench for cnn_layer_accel_seq_fetch: latency-2 memory returning data=addr,
// scoreboard queues for read addresses and popped words, table-driven jobs plus corner sequences.
module tb_cnn_layer_accel_seq_fetch;

  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 2560;
  localparam int unsigned A     = 12;
  localparam int unsigned LAT   = 2;
  localparam int unsigned FD    = 8;

  typedef struct {
    logic [A-1:0] base;
    logic [A:0]   len;
    logic [15:0]  passes;
    bit           hold_high;
    int           exp_words;
    bit           exp_underrun;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [A-1:0]  base = '0;
  logic [A:0]    len = '0;
  logic [15:0]   passes = '0;
  logic          rden = 1'b0;
  logic          busy, done, underrun;
  logic [A-1:0]  pipe_addr [LAT];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;
  int n_reads = 0;
  int n_pops  = 0;
  int last_pop_cyc = -10;
  bit stream_seen = 1'b0;
  bit got_done;
  logic [W-1:0] exp_q [$];
  logic [A-1:0] addr_q [$];
  vec_t vecs [6];

  cnn_layer_accel_seq_fetch_if #(.W(W), .A(A)) bus ();

  cnn_layer_accel_seq_fetch #(
    .C_SEQ_DATA_WIDTH(W), .C_SEQ_DATA_DEPTH(DEPTH), .C_MEM_LATENCY(LAT), .C_FIFO_DEPTH(FD)
  ) dut (
    .clk_500MHz(clk), .accel_rst_n(rst_n), .i_start(start), .i_seq_base(base),
    .i_seq_len(len), .i_num_passes(passes), .o_busy(busy), .o_done(done),
    .o_underrun(underrun), .seq_if(bus)
  );

  always #5 clk = ~clk;

  // Sequence memory model: data = address, LAT cycles after the strobe; never reset.
  always @(posedge clk) begin
    pipe_addr[0] <= bus.mem_rd_addr;
    for (int i = 1; i < int'(LAT); i++) pipe_addr[i] <= pipe_addr[i-1];
  end
  assign bus.mem_rd_data = W'(pipe_addr[LAT-1]);
  assign bus.seq_rden    = rden;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  // One clock: entered and left at posedge+1, outputs already settled.
  task automatic cyc(input bit rd);
    rden = rd;
    if (bus.mem_rd_en) begin
      n_reads++;
      if (addr_q.size() == 0) check("extra_read", 1, 0);
      else check("rd_addr", 32'(bus.mem_rd_addr), 32'(addr_q.pop_front()));
    end
    if (busy) check("occupancy_le_depth", 32'(n_reads - n_pops <= int'(FD)), 1);
    if (rd && bus.seq_dataout_valid) begin
      if (exp_q.size() == 0) check("extra_pop", 1, 0);
      else check("pop_data", 32'(bus.seq_dataout), 32'(exp_q.pop_front()));
      n_pops++;
      last_pop_cyc = cyc_n;
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic start_job(input logic [A-1:0] b, input logic [A:0] l, input logic [15:0] p,
                           input bit accept);
    start = 1'b1; base = b; len = l; passes = p;
    if (accept) begin
      n_reads = 0; n_pops = 0; stream_seen = 1'b0; last_pop_cyc = -10;
      for (int pi = 0; pi < int'(p); pi++) begin
        for (int o = 0; o < int'(l); o++) begin
          addr_q.push_back(A'((int'(b) + o) % int'(DEPTH)));
          exp_q.push_back(W'((int'(b) + o) % int'(DEPTH)));
        end
      end
    end
    cyc(1'b0);
    start = 1'b0;
  endtask

  task automatic run_until_done(input bit hold_high, input int budget, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (bus.seq_dataout_valid) stream_seen = 1'b1;
      cyc((exp_q.size() > 0) && (hold_high || (stream_seen && ($urandom_range(1, 0) == 1))));
    end
    check("done_seen", 32'(seen), 1);
  endtask

  task automatic wait_valid(input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (bus.seq_dataout_valid) begin
        seen = 1'b1;
        break;
      end
      cyc(1'b0);
    end
    check("stream_reached", 32'(seen), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{base: 12'd0,    len: 13'd4, passes: 16'd1, hold_high: 1'b1, exp_words: 4,  exp_underrun: 1'b1};
    vecs[1] = '{base: 12'd2558, len: 13'd4, passes: 16'd1, hold_high: 1'b0, exp_words: 4,  exp_underrun: 1'b0};
    vecs[2] = '{base: 12'd0,    len: 13'd3, passes: 16'd3, hold_high: 1'b0, exp_words: 9,  exp_underrun: 1'b0};
    vecs[3] = '{base: 12'd100,  len: 13'd5, passes: 16'd2, hold_high: 1'b1, exp_words: 10, exp_underrun: 1'b1};
    vecs[4] = '{base: 12'd7,    len: 13'd0, passes: 16'd5, hold_high: 1'b1, exp_words: 0,  exp_underrun: 1'b0};
    vecs[5] = '{base: 12'd7,    len: 13'd3, passes: 16'd0, hold_high: 1'b0, exp_words: 0,  exp_underrun: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_rd_en", 32'(bus.mem_rd_en), 0);
    check("rst_valid", 32'(bus.seq_dataout_valid), 0);

    for (int i = 0; i < 6; i++) begin
      start_job(vecs[i].base, vecs[i].len, vecs[i].passes, 1'b1);
      run_until_done(vecs[i].hold_high, 2000, got_done);
      check("job_busy_with_done", 32'(busy), 0);
      check("job_words", 32'(n_pops), 32'(vecs[i].exp_words));
      check("job_words_left", 32'(exp_q.size()), 0);
      check("job_addrs_left", 32'(addr_q.size()), 0);
      check("job_underrun", 32'(underrun), 32'(vecs[i].exp_underrun));
      if (vecs[i].exp_words > 0) check("done_after_last_pop", 32'(cyc_n - last_pop_cyc), 1);
      cyc(1'b0);
      check("done_one_cycle", 32'(done), 0);
    end

    // Stall: no pops for 50 cycles after start.
    start_job(12'd0, 13'd20, 16'd1, 1'b1);
    for (int k = 0; k < 50; k++) cyc(1'b0);
    check("stall_reads", 32'(n_reads), 8);
    check("stall_valid", 32'(bus.seq_dataout_valid), 1);
    check("stall_busy", 32'(busy), 1);
    run_until_done(1'b1, 2000, got_done);
    check("stall_words", 32'(n_pops), 20);

    // Pop attempt during prefill, then a start while streaming.
    start_job(12'd0, 13'd20, 16'd1, 1'b1);
    cyc(1'b1);
    check("prefill_underrun", 32'(underrun), 1);
    check("prefill_no_pop", 32'(exp_q.size()), 20);
    wait_valid(100);
    start_job(12'd500, 13'd3, 16'd2, 1'b0);
    check("restart_ignored_busy", 32'(busy), 1);
    run_until_done(1'b1, 2000, got_done);
    check("restart_words", 32'(n_pops), 20);
    check("restart_underrun_kept", 32'(underrun), 1);
    cyc(1'b0);

    // Reset with reads in flight.
    start_job(12'd0, 13'd20, 16'd1, 1'b1);
    wait_valid(100);
    cyc(1'b1);
    cyc(1'b1);
    for (int k = 0; k < 10; k++) begin
      if (bus.mem_rd_en) break;
      cyc(1'b0);
    end
    check("pre_reset_rd_en", 32'(bus.mem_rd_en), 1);
    cyc(1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_underrun", 32'(underrun), 0);
    check("mid_rst_rd_en", 32'(bus.mem_rd_en), 0);
    check("mid_rst_addr", 32'(bus.mem_rd_addr), 0);
    check("mid_rst_valid", 32'(bus.seq_dataout_valid), 0);
    check("mid_rst_dout", 32'(bus.seq_dataout), 0);
    @(posedge clk);
    #1;
    cyc_n++;
    rst_n = 1'b1;
    exp_q.delete();
    addr_q.delete();
    start_job(12'd40, 13'd2, 16'd1, 1'b1);
    run_until_done(1'b1, 2000, got_done);
    check("post_rst_words", 32'(n_pops), 2);
    check("post_rst_words_left", 32'(exp_q.size()), 0);
    cyc(1'b0);
    check("post_rst_no_extra_valid", 32'(bus.seq_dataout_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
